// File: rtl/wptr_ctrl_lvl.sv
// Write-side pointer controller for an asynchronous FIFO (write clock domain).
// Advances the binary write count, publishes a Gray pointer, and derives full/level status.
module wptr_ctrl_lvl #(
  parameter int unsigned ADDR_LEN     = 8,
  parameter int unsigned AFULL_THRESH = (1 << ADDR_LEN) - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                wincr_i,
  input  logic [ADDR_LEN:0]   r2wptr_sync_i,
  input  logic                wovf_clr_i,
  output logic [ADDR_LEN-1:0] fifo_waddr_o,
  output logic                fifo_wen_o,
  output logic [ADDR_LEN:0]   wptr_o,
  output logic                wfull_o,
  output logic                walmost_full_o,
  output logic [ADDR_LEN:0]   wlevel_o,
  output logic                woverflow_o
);

  localparam logic [ADDR_LEN:0] AFULL_LVL = AFULL_THRESH[ADDR_LEN:0];

  logic [ADDR_LEN:0] wbin_q, wbin_d;
  logic [ADDR_LEN:0] wptr_q, wgray_d;
  logic [ADDR_LEN:0] wlevel_q, level_d;
  logic [ADDR_LEN:0] rbin;
  logic              wfull_q, wfull_d;
  logic              wafull_q, wafull_d;
  logic              wovf_q, wovf_d;
  logic              wpush;

  assign wpush = wincr_i & ~wfull_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rbin           = '0;
    rbin[ADDR_LEN] = r2wptr_sync_i[ADDR_LEN];
    for (int i = int'(ADDR_LEN) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ r2wptr_sync_i[i];
    end

    wbin_d   = wbin_q + {{ADDR_LEN{1'b0}}, wpush};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    level_d  = wbin_d - rbin;
    wafull_d = (level_d >= AFULL_LVL);
    // The FIFO is full when the pointers differ only in their top two Gray bits.
    wfull_d  = (wgray_d == {~r2wptr_sync_i[ADDR_LEN:ADDR_LEN-1],
                            r2wptr_sync_i[ADDR_LEN-2:0]});

    wovf_d = wovf_q;
    if (wincr_i && wfull_q) begin
      wovf_d = 1'b1;
    end else if (wovf_clr_i) begin
      wovf_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= level_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign fifo_waddr_o   = wbin_q[ADDR_LEN-1:0];
  assign fifo_wen_o     = wpush;
  assign wptr_o         = wptr_q;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = wafull_q;
  assign wlevel_o       = wlevel_q;
  assign woverflow_o    = wovf_q;

endmodule

// File: tb/tb_wptr_ctrl_lvl.sv
// Self-checking bench for wptr_ctrl_lvl: directed plan steps plus random traffic,
// compared against a write/read occupancy-count model.
module tb_wptr_ctrl_lvl;

  localparam int AL = 3;
  localparam int TH = 6;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          wincr_i = 1'b0;
  logic [AL:0]   r2wptr_sync_i = '0;
  logic          wovf_clr_i = 1'b0;
  logic [AL-1:0] fifo_waddr_o;
  logic          fifo_wen_o;
  logic [AL:0]   wptr_o;
  logic          wfull_o;
  logic          walmost_full_o;
  logic [AL:0]   wlevel_o;
  logic          woverflow_o;

  wptr_ctrl_lvl #(.ADDR_LEN(AL), .AFULL_THRESH(TH)) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .wincr_i        (wincr_i),
    .r2wptr_sync_i  (r2wptr_sync_i),
    .wovf_clr_i     (wovf_clr_i),
    .fifo_waddr_o   (fifo_waddr_o),
    .fifo_wen_o     (fifo_wen_o),
    .wptr_o         (wptr_o),
    .wfull_o        (wfull_o),
    .walmost_full_o (walmost_full_o),
    .wlevel_o       (wlevel_o),
    .woverflow_o    (woverflow_o)
  );

  always #5 wclk = ~wclk;

  int tests = 0;
  int fails = 0;

  // Reference model: total accepted writes and the read count last presented.
  int m_wcnt = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_afull = 0;
  bit m_ovf = 0;
  bit last_acc = 0;

  function automatic logic [AL:0] gray(input int n);
    int m;
    m = n & 15;
    return 4'((m >> 1) ^ m);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":ptr"},   32'(wptr_o),         32'(gray(m_wcnt)));
    check({tag, ":waddr"}, 32'(fifo_waddr_o),   32'(m_wcnt & 7));
    check({tag, ":level"}, 32'(wlevel_o),       32'(m_level));
    check({tag, ":full"},  32'(wfull_o),        32'(m_full));
    check({tag, ":afull"}, 32'(walmost_full_o), 32'(m_afull));
    check({tag, ":ovf"},   32'(woverflow_o),    32'(m_ovf));
  endtask

  // One clock: drive at negedge, check the combinational enable, clock, update model, check.
  task automatic step(input bit inc, input int rc, input bit clr, input bit rst, input string tag);
    @(negedge wclk);
    wrst          = rst;
    wincr_i       = inc;
    r2wptr_sync_i = gray(rc);
    wovf_clr_i    = clr;
    #1;
    if (!rst) begin
      check({tag, ":wen"},   32'(fifo_wen_o),   32'(inc && !m_full));
      check({tag, ":waddr0"}, 32'(fifo_waddr_o), 32'(m_wcnt & 7));
    end
    @(posedge wclk);
    if (rst) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; last_acc = 0;
    end else begin
      last_acc = inc && !m_full;
      if (inc && m_full) m_ovf = 1;
      else if (clr)      m_ovf = 0;
      m_wcnt  = m_wcnt + int'(last_acc);
      m_level = (m_wcnt - rc) & 15;
      m_full  = (m_level == 8);
      m_afull = (m_level >= TH);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [AL:0] prev_ptr;
    int rc;

    // 1. Reset with write request held high
    step(1, 0, 0, 1, "rst0");
    step(1, 0, 0, 1, "rst1");
    check("rst_level", 32'(wlevel_o), 0);
    check("rst_waddr", 32'(fifo_waddr_o), 0);

    // 2. Fill with the read pointer parked at 0
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0, "fill");
      if (i == 6) begin
        check("fill6_afull", 32'(walmost_full_o), 1);
        check("fill6_level", 32'(wlevel_o), 6);
      end
    end
    check("fill8_full",  32'(wfull_o), 1);
    check("fill8_ptr",   32'(wptr_o), 32'hC);
    check("fill8_level", 32'(wlevel_o), 8);
    check("fill8_waddr", 32'(fifo_waddr_o), 0);

    // 3. Overflow set, clear, and set-wins-over-clear
    step(1, 0, 0, 0, "ovf_set");
    check("ovf_set_flag", 32'(woverflow_o), 1);
    check("ovf_ptr_hold", 32'(wptr_o), 32'hC);
    step(0, 0, 1, 0, "ovf_clr");
    check("ovf_clr_flag", 32'(woverflow_o), 0);
    step(1, 0, 1, 0, "ovf_both");
    check("ovf_both_flag", 32'(woverflow_o), 1);

    // 4. One read frees a slot, one write refills
    step(0, 1, 0, 0, "drain");
    check("drain_full",  32'(wfull_o), 0);
    check("drain_level", 32'(wlevel_o), 7);
    step(1, 1, 0, 0, "refill");
    check("refill_full", 32'(wfull_o), 1);
    check("refill_ptr",  32'(wptr_o), 32'hD);

    // 5. Continuous write with the reader 2 behind, across the count wrap
    prev_ptr = wptr_o;
    for (int i = 0; i < 41; i++) begin
      step(1, m_wcnt - 1, 1, 0, "wrap");
      check("wrap_1bit", $countones(prev_ptr ^ wptr_o), 32'(last_acc));
      prev_ptr = wptr_o;
      if (i > 0) begin
        check("wrap_level2", 32'(wlevel_o), 2);
        check("wrap_nofull", 32'(wfull_o), 0);
      end
    end

    // 6. Reset in the middle of a fill
    step(0, 0, 0, 1, "rst_a");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, "mid");
    check("mid_level5", 32'(wlevel_o), 5);
    step(1, 0, 0, 1, "rst_mid");
    check("rst_mid_level", 32'(wlevel_o), 0);
    check("rst_mid_ptr",   32'(wptr_o), 0);
    check("rst_mid_waddr", 32'(fifo_waddr_o), 0);

    // Random traffic; the reader never passes the writer
    rc = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rc = 0;
        step(1, 0, 0, 1, "rnd_rst");
      end else begin
        if ($urandom_range(0, 2) == 0 && rc < m_wcnt) rc++;
        step(1'($urandom_range(0, 3) != 0), rc, 1'($urandom_range(0, 7) == 0), 0, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
